// File: rtl/gelato_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   wb_req_t          : one writeback request (warp, register, lane mask, lane data)
//   WB_SRC_NUM        : default number of writeback requesters
//   WB_STARVE_LIMIT   : default wait cycles before a requester jumps the round-robin
//   wb_is_discard()   : true when a write has no architectural effect
package gelato_writeback_arbiter_pkg;

  localparam int unsigned GELATO_THREAD_NUM = 32;
  localparam int unsigned GELATO_XLEN       = 32;
  localparam int unsigned GELATO_WARP_W     = 5;
  localparam int unsigned GELATO_REG_W      = 5;

  localparam int unsigned WB_SRC_NUM      = 4;
  localparam int unsigned WB_STARVE_LIMIT = 15;

  typedef logic [GELATO_WARP_W-1:0]                 warp_num_t;
  typedef logic [GELATO_REG_W-1:0]                  reg_num_t;
  typedef logic [GELATO_THREAD_NUM-1:0]             thread_mask_t;
  typedef logic [GELATO_THREAD_NUM*GELATO_XLEN-1:0] data_t;

  typedef struct packed {
    warp_num_t    warp_num;
    reg_num_t     reg_num;
    thread_mask_t thread_mask;
    data_t        data;
  } wb_req_t;

  // Register 0 is hard-wired and an empty mask touches no lane: neither reaches the
  // register file, but the scoreboard entry must still be released.
  function automatic logic wb_is_discard(input reg_num_t reg_num, input thread_mask_t mask);
    return (reg_num == '0) || (mask == '0);
  endfunction

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Combinational round-robin arbiter with a priority-override vector.
//   req_i   : request vector
//   prio_i  : override vector; the lowest requesting index set here wins outright
//   en_i    : grant enable; no grant when low
//   ptr_i   : current round-robin start index
//   grant_o : one-hot grant (or zero)
//   ptr_o   : pointer to register next (winner + 1, wrapping); ptr_i when no grant
module gelato_rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [N-1:0]    prio_i,
  input  logic            en_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    grant_o,
  output logic [PtrW-1:0] ptr_o
);

  localparam int unsigned IdxW = PtrW + 1;
  localparam logic [IdxW-1:0] NumW    = IdxW'(N);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(N - 1);

  logic [N-1:0]    pri_req;
  logic [PtrW-1:0] sel;
  logic            hit;
  logic [IdxW-1:0] idx;

  assign pri_req = req_i & prio_i;

  always_comb begin
    sel = '0;
    hit = 1'b0;
    idx = '0;
    if (|pri_req) begin
      // Descending scan so the lowest index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
        if (pri_req[i]) begin
          sel = PtrW'(i);
          hit = 1'b1;
        end
      end
    end else begin
      // Descending offset scan: the requester closest to ptr_i ends up selected.
      for (int k = N - 1; k >= 0; k--) begin
        idx = {1'b0, ptr_i} + IdxW'(k);
        if (idx >= NumW) begin
          idx = idx - NumW;
        end
        if (req_i[idx[PtrW-1:0]]) begin
          sel = idx[PtrW-1:0];
          hit = 1'b1;
        end
      end
    end

    grant_o = '0;
    ptr_o   = ptr_i;
    if (en_i && hit) begin
      grant_o[sel] = 1'b1;
      ptr_o        = (sel == LastIdx) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/gelato_writeback_arbiter.sv
// Shares the single register-file writeback port among NUM_SRC execution units.
// Round-robin arbitration with a starvation override feeds a one-entry output stage;
// every granted write also pulses a one-cycle scoreboard clear.
//   clk_i, rst_i (async, active high), rdy_i (global enable, 0 freezes the block)
//   src_*_i / src_ready_o : per-source valid/ready request channel
//   wb_*_o / wb_ready_i   : registered writeback channel to the register file arbiter
//   sb_clear_*_o          : scoreboard release pulse, one per retired write
module gelato_writeback_arbiter
  import gelato_writeback_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC      = WB_SRC_NUM,
  parameter int unsigned THREAD_NUM   = GELATO_THREAD_NUM,
  parameter int unsigned XLEN         = GELATO_XLEN,
  parameter int unsigned WARP_W       = GELATO_WARP_W,
  parameter int unsigned REG_W        = GELATO_REG_W,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    rdy_i,
  input  logic [NUM_SRC-1:0]                      src_valid_i,
  output logic [NUM_SRC-1:0]                      src_ready_o,
  input  logic [NUM_SRC-1:0][WARP_W-1:0]          src_warp_num_i,
  input  logic [NUM_SRC-1:0][REG_W-1:0]           src_reg_num_i,
  input  logic [NUM_SRC-1:0][THREAD_NUM-1:0]      src_thread_mask_i,
  input  logic [NUM_SRC-1:0][THREAD_NUM*XLEN-1:0] src_data_i,
  output logic                                    wb_valid_o,
  input  logic                                    wb_ready_i,
  output logic [WARP_W-1:0]                       wb_warp_num_o,
  output logic [REG_W-1:0]                        wb_reg_num_o,
  output logic [THREAD_NUM-1:0]                   wb_thread_mask_o,
  output logic [THREAD_NUM*XLEN-1:0]              wb_data_o,
  output logic                                    sb_clear_valid_o,
  output logic [WARP_W-1:0]                       sb_clear_warp_o,
  output logic [REG_W-1:0]                        sb_clear_reg_o
);

  localparam int unsigned PtrW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

  logic                          load_en;
  logic [NUM_SRC-1:0]            starve;
  logic [NUM_SRC-1:0]            grant;
  logic                          any_grant;
  wb_req_t                       sel_req;

  logic [PtrW-1:0]               ptr_q, ptr_d;
  logic [NUM_SRC-1:0][CntW-1:0]  wait_q, wait_d;
  logic                          wb_valid_q, wb_valid_d;
  wb_req_t                       wb_q, wb_d;
  logic                          sb_valid_q, sb_valid_d;
  warp_num_t                     sb_warp_q, sb_warp_d;
  reg_num_t                      sb_reg_q, sb_reg_d;

  // The stage can take a new entry when empty or draining this cycle. Gating with rst_i
  // keeps src_ready low while reset is held.
  assign load_en   = rdy_i && !rst_i && (!wb_valid_q || wb_ready_i);
  assign any_grant = |grant;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      starve[i] = src_valid_i[i] && (wait_q[i] == CntMax);
    end
  end

  gelato_rr_arbiter #(
    .N (NUM_SRC)
  ) u_rr_arbiter (
    .req_i   (src_valid_i),
    .prio_i  (starve),
    .en_i    (load_en),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .ptr_o   (ptr_d)
  );

  assign src_ready_o = grant;

  // Grant is one-hot, so a plain select is enough.
  always_comb begin
    sel_req = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) begin
        sel_req.warp_num    = src_warp_num_i[i];
        sel_req.reg_num     = src_reg_num_i[i];
        sel_req.thread_mask = src_thread_mask_i[i];
        sel_req.data        = src_data_i[i];
      end
    end
  end

  // A requester that drops valid forgets its wait history immediately; otherwise the
  // counter only advances on active (rdy_i) cycles where it lost.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!src_valid_i[i] || grant[i]) begin
        wait_d[i] = '0;
      end else if (rdy_i && (wait_q[i] != CntMax)) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end else begin
        wait_d[i] = wait_q[i];
      end
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_d       = wb_q;
    sb_valid_d = 1'b0;
    sb_warp_d  = sb_warp_q;
    sb_reg_d   = sb_reg_q;
    if (any_grant) begin
      sb_valid_d = 1'b1;
      sb_warp_d  = sel_req.warp_num;
      sb_reg_d   = sel_req.reg_num;
      // A grant implies the stage is empty or draining, so a discard leaves it empty.
      if (wb_is_discard(sel_req.reg_num, sel_req.thread_mask)) begin
        wb_valid_d = 1'b0;
      end else begin
        wb_valid_d = 1'b1;
        wb_d       = sel_req;
      end
    end else if (rdy_i && wb_ready_i) begin
      wb_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q      <= '0;
      wait_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_q       <= '0;
      sb_valid_q <= 1'b0;
      sb_warp_q  <= '0;
      sb_reg_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wait_q     <= wait_d;
      wb_valid_q <= wb_valid_d;
      wb_q       <= wb_d;
      sb_valid_q <= sb_valid_d;
      sb_warp_q  <= sb_warp_d;
      sb_reg_q   <= sb_reg_d;
    end
  end

  assign wb_valid_o       = wb_valid_q;
  assign wb_warp_num_o    = wb_q.warp_num;
  assign wb_reg_num_o     = wb_q.reg_num;
  assign wb_thread_mask_o = wb_q.thread_mask;
  assign wb_data_o        = wb_q.data;
  assign sb_clear_valid_o = sb_valid_q;
  assign sb_clear_warp_o  = sb_warp_q;
  assign sb_clear_reg_o   = sb_reg_q;

endmodule

// File: tb/tb_gelato_writeback_arbiter.sv
module tb_gelato_writeback_arbiter;

  localparam int N   = 4;
  localparam int LIM = 15;

  logic                clk;
  logic                rst;
  logic                rdy;
  logic [N-1:0]        src_valid;
  logic [N-1:0]        src_ready;
  logic [N-1:0][4:0]   src_warp;
  logic [N-1:0][4:0]   src_reg;
  logic [N-1:0][31:0]  src_mask;
  logic [N-1:0][1023:0] src_data;
  logic                wb_valid;
  logic                wb_ready;
  logic [4:0]          wb_warp;
  logic [4:0]          wb_reg;
  logic [31:0]         wb_mask;
  logic [1023:0]       wb_data;
  logic                sb_valid;
  logic [4:0]          sb_warp;
  logic [4:0]          sb_reg;

  gelato_writeback_arbiter dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .rdy_i             (rdy),
    .src_valid_i       (src_valid),
    .src_ready_o       (src_ready),
    .src_warp_num_i    (src_warp),
    .src_reg_num_i     (src_reg),
    .src_thread_mask_i (src_mask),
    .src_data_i        (src_data),
    .wb_valid_o        (wb_valid),
    .wb_ready_i        (wb_ready),
    .wb_warp_num_o     (wb_warp),
    .wb_reg_num_o      (wb_reg),
    .wb_thread_mask_o  (wb_mask),
    .wb_data_o         (wb_data),
    .sb_clear_valid_o  (sb_valid),
    .sb_clear_warp_o   (sb_warp),
    .sb_clear_reg_o    (sb_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit            m_wv;
  logic [4:0]    m_warp, m_reg, m_sbw, m_sbr;
  logic [31:0]   m_mask;
  logic [1023:0] m_data;
  bit            m_sbv;
  int            m_ptr;
  int            m_wait[N];
  int            last_g;
  int            obs_g;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (low 192 bits)", tag, obs[191:0], exp[191:0]);
    end
  endtask

  task automatic model_reset();
    m_wv = 0; m_warp = '0; m_reg = '0; m_mask = '0; m_data = '0;
    m_sbv = 0; m_sbw = '0; m_sbr = '0; m_ptr = 0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  // Who should win this cycle, from the arbitration rules.
  function automatic int model_grant();
    if (!(rdy && (!m_wv || wb_ready))) return -1;
    for (int i = 0; i < N; i++) if (src_valid[i] && m_wait[i] == LIM) return i;
    for (int k = 0; k < N; k++) if (src_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  task automatic model_step(input int g);
    for (int i = 0; i < N; i++) begin
      if (!src_valid[i] || i == g) m_wait[i] = 0;
      else if (rdy && m_wait[i] < LIM) m_wait[i] = m_wait[i] + 1;
    end
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_sbv = 1; m_sbw = src_warp[g]; m_sbr = src_reg[g];
      if (src_reg[g] == 0 || src_mask[g] == 0) m_wv = 0;
      else begin
        m_wv = 1; m_warp = src_warp[g]; m_reg = src_reg[g];
        m_mask = src_mask[g]; m_data = src_data[g];
      end
    end else begin
      m_sbv = 0;
      if (rdy && m_wv && wb_ready) m_wv = 0;
    end
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next one.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    #1;
    last_g = model_grant();
    exp_rdy = '0;
    if (last_g >= 0) exp_rdy[last_g] = 1'b1;
    obs_g = -1;
    for (int i = 0; i < N; i++) if (src_ready[i]) obs_g = i;
    chk("src_ready", src_ready, exp_rdy);
    chk("wb_valid", wb_valid, m_wv);
    chk("wb_warp", wb_warp, m_warp);
    chk("wb_reg", wb_reg, m_reg);
    chk("wb_mask", wb_mask, m_mask);
    chk("wb_data", wb_data, m_data);
    chk("sb_valid", sb_valid, m_sbv);
    chk("sb_warp", sb_warp, m_sbw);
    chk("sb_reg", sb_reg, m_sbr);
    model_step(last_g);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic new_payload(input int i, input bit allow_discard);
    src_warp[i] = 5'($urandom_range(0, 31));
    src_reg[i]  = 5'($urandom_range(allow_discard ? 0 : 1, 31));
    src_mask[i] = $urandom();
    if (allow_discard && $urandom_range(0, 7) == 0) src_mask[i] = '0;
    if (!allow_discard && src_mask[i] == '0) src_mask[i] = 32'h1;
    for (int w = 0; w < 32; w++) src_data[i][w*32 +: 32] = $urandom();
  endtask

  task automatic set_src(input int i, input logic [4:0] w, input logic [4:0] r,
                         input logic [31:0] m);
    new_payload(i, 1'b1);
    src_warp[i] = w; src_reg[i] = r; src_mask[i] = m;
    src_valid[i] = 1'b1;
  endtask

  // A continuously busy source presents a fresh write right after each accept.
  task automatic keep_busy();
    if (last_g >= 0 && src_valid[last_g]) new_payload(last_g, 1'b0);
  endtask

  initial begin
    int exp_seq[4];
    exp_seq = '{0, 2, 0, 2};
    last_g = -1;
    obs_g = -1;

    // Reset: outputs cleared and no accept even with every source requesting.
    rst = 1'b1; rdy = 1'b1; wb_ready = 1'b1;
    src_valid = '0; src_warp = '0; src_reg = '0; src_mask = '0; src_data = '0;
    for (int i = 0; i < N; i++) set_src(i, 5'(i + 1), 5'(i + 1), 32'hFFFF);
    #2;
    chk("rst_src_ready", src_ready, 4'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_wb_data", wb_data, '0);
    chk("rst_sb_valid", sb_valid, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    src_valid = '0;

    // Sources 0 and 2 continuously valid: alternate, output stays full.
    new_payload(0, 1'b0); new_payload(2, 1'b0);
    src_valid = 4'b0101;
    for (int j = 0; j < 4; j++) begin
      cycle();
      chk("rr_alternate", obs_g, exp_seq[j]);
      chk("b2b_wb_valid", wb_valid, 1'b1);
      keep_busy();
    end
    src_valid = '0;
    cycle();

    // Source 1 held off by wb_ready=0: payload stable, scoreboard pulses once.
    set_src(1, 5'd3, 5'd7, 32'hFFFF_FFFF);
    cycle();
    chk("hold_grant", obs_g, 1);
    src_valid[1] = 1'b0;
    wb_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk("hold_wb_valid", wb_valid, 1'b1);
      chk("hold_wb_warp", wb_warp, 5'd3);
      chk("hold_wb_reg", wb_reg, 5'd7);
      chk("hold_wb_mask", wb_mask, 32'hFFFF_FFFF);
      chk("hold_sb_pulse", sb_valid, (j == 0));
      if (j < 3) cycle();
    end
    wb_ready = 1'b1;
    cycle();
    chk("drained", wb_valid, 1'b0);

    // Discard write to register 0: accepted, not forwarded, scoreboard still cleared.
    set_src(3, 5'd9, 5'd0, 32'h0F0F_0F0F);
    cycle();
    chk("discard_grant", obs_g, 3);
    src_valid[3] = 1'b0;
    chk("discard_wb_valid", wb_valid, 1'b0);
    chk("discard_sb_valid", sb_valid, 1'b1);
    chk("discard_sb_reg", sb_reg, 5'd0);
    chk("discard_sb_warp", sb_warp, 5'd9);

    // Starvation: source 3 waits 15 stalled cycles and then beats the pointer at 0.
    wb_ready = 1'b0;
    new_payload(3, 1'b0); src_valid[3] = 1'b1;
    cycle();
    keep_busy();
    for (int j = 0; j < 15; j++) begin
      if (j == 5) begin
        new_payload(0, 1'b0); new_payload(1, 1'b0);
        src_valid[0] = 1'b1; src_valid[1] = 1'b1;
      end
      cycle();
      chk("stall_no_grant", obs_g, -1);
    end
    wb_ready = 1'b1;
    cycle();
    chk("starve_winner", obs_g, 3);
    keep_busy();
    cycle();
    chk("starve_cnt_cleared", obs_g, 0);
    keep_busy();

    // All three saturate; lowest index first, others keep their priority.
    wb_ready = 1'b0;
    for (int j = 0; j < 16; j++) cycle();
    wb_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("multi_limit", obs_g, (j == 2) ? 3 : j);
      keep_busy();
    end

    // rdy=0 freezes everything even with wb_ready=1.
    rdy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      cycle();
      chk("frozen_grant", obs_g, -1);
      chk("frozen_wb_valid", wb_valid, 1'b1);
    end
    rdy = 1'b1;
    cycle();
    chk("resume_grant", obs_g, 0);
    keep_busy();

    // Reset in the middle of a transfer.
    chk("pre_rst_wb_valid", wb_valid, 1'b1);
    chk("pre_rst_sb_valid", sb_valid, 1'b1);
    src_valid = 4'b0110;
    rst = 1'b1;
    #1;
    chk("async_rst_wb_valid", wb_valid, 1'b0);
    chk("async_rst_sb_valid", sb_valid, 1'b0);
    chk("async_rst_ready", src_ready, 4'b0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    chk("post_rst_grant", obs_g, 1);
    keep_busy();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rdy = ($urandom_range(0, 9) != 0);
      wb_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!src_valid[i] && $urandom_range(0, 2) == 0) begin
          new_payload(i, 1'b1);
          src_valid[i] = 1'b1;
        end
      end
      cycle();
      if (last_g >= 0) begin
        src_valid[last_g] = 1'($urandom_range(0, 1));
        new_payload(last_g, 1'b1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
